// File: rtl/dma_xfer_engine_pkg.sv
// dma_pkg: shared types and constants for the DMA transfer engine.
//   dma_state_e   - engine FSM state encoding
//   HTRANS_*      - the two AHB transfer types the engine ever drives
//   HRESP_ERR     - AHB HRESP value that signals an error response
//   hsize_of()    - HSIZE encoding for a given data-bus width
//   idx_width()   - index width for a channel count (at least one bit)
package dma_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ARB   = 4'd1,
    ST_RD_A  = 4'd2,
    ST_RD_D  = 4'd3,
    ST_WR_A  = 4'd4,
    ST_WR_D  = 4'd5,
    ST_DONE  = 4'd6,
    ST_ABORT = 4'd7,
    ST_ERR   = 4'd8
  } dma_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic       HRESP_ERR     = 1'b1;

  // HSIZE is log2 of the beat size in bytes.
  function automatic logic [2:0] hsize_of(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

  // A single channel still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_xfer_engine_if.sv
// dma_xfer_engine_if: AHB-Lite master bus of the DMA transfer engine.
//   htrans/hsize/hwrite/haddr/hwdata - driven by the master (engine)
//   hready/hresp/hrdata              - driven by the slave side
// Modports: master (engine side), slave (memory/peripheral side).
interface dma_xfer_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic              hwrite;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output htrans, hsize, hwrite, haddr, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  htrans, hsize, hwrite, haddr, hwdata,
    output hready, hresp, hrdata
  );

endinterface

// File: rtl/dma_xfer_engine_arb.sv
// dma_rr_arbiter: round-robin channel arbiter.
//   clk, rst   - clock, asynchronous active-high reset
//   req        - eligible-channel vector (enable & request)
//   advance    - strobe: the current grant is being taken
//   grant      - one-hot winner, combinational
//   grant_idx  - binary index of the winner, combinational
//   found      - at least one channel is eligible
// The search starts one above the last granted index and wraps, so a channel
// that has just been served has the lowest priority next time.
module dma_rr_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              found
);

  logic [IDX_W-1:0] ptr_r;

  // Scan upward from ptr_r+1 with wrap; the first eligible channel wins.
  always_comb begin
    int cand_s;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand_s    = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand_s = (int'(ptr_r) + k) % NUM_CH;
      if (!found && req[IDX_W'(cand_s)]) begin
        grant[IDX_W'(cand_s)] = 1'b1;
        grant_idx             = IDX_W'(cand_s);
        found                 = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Park the pointer on the channel just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (advance && found) begin
      ptr_r <= grant_idx;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/dma_xfer_engine.sv
// dma_xfer_engine: NUM_CH-channel DMA engine behind one AHB-Lite master.
//   clk, rst      - system clock, asynchronous active-high reset
//   ch_en         - per-channel enable
//   ch_src/ch_dst - per-channel start addresses, ch i at [i*ADDR_W +: ADDR_W]
//   ch_size       - per-channel length in words, ch i at [i*SIZE_W +: SIZE_W]
//   ch_src_inc    - 1: source advances one word per beat, 0: fixed
//   ch_dst_inc    - 1: destination advances one word per beat, 0: fixed
//   req           - per-channel peripheral request (level)
//   ack/done/err  - one-cycle completion pulses for the granted channel
//   busy          - engine not idle
//   ahb           - AHB-Lite master port
// Each word is moved as a single read beat followed by a single write beat
// through a one-word buffer; beats are never overlapped.
module dma_xfer_engine
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*ADDR_W-1:0] ch_src,
  input  logic [NUM_CH*ADDR_W-1:0] ch_dst,
  input  logic [NUM_CH*SIZE_W-1:0] ch_size,
  input  logic [NUM_CH-1:0]        ch_src_inc,
  input  logic [NUM_CH-1:0]        ch_dst_inc,
  input  logic [NUM_CH-1:0]        req,
  output logic [NUM_CH-1:0]        ack,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        err,
  output logic                     busy,
  dma_xfer_engine_if.master        ahb
);

  localparam int               IDX_W   = idx_width(NUM_CH);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(DATA_W / 8);
  localparam logic [2:0]        HSIZE_C = hsize_of(DATA_W);

  // FSM and work registers
  dma_state_e        state_r;
  logic [NUM_CH-1:0] gnt_r;
  logic [ADDR_W-1:0] src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [SIZE_W-1:0] count_r;
  logic              src_inc_r;
  logic              dst_inc_r;
  logic [DATA_W-1:0] buf_r;

  // Registered outputs
  logic [1:0]        htrans_r;
  logic              hwrite_r;
  logic [ADDR_W-1:0] haddr_r;
  logic [DATA_W-1:0] hwdata_r;
  logic [NUM_CH-1:0] ack_r;
  logic [NUM_CH-1:0] done_r;
  logic [NUM_CH-1:0] err_r;
  logic              busy_r;

  // Combinational helpers
  logic [NUM_CH-1:0] elig_s;
  logic              any_elig_s;
  logic [NUM_CH-1:0] arb_grant_s;
  logic [IDX_W-1:0]  arb_idx_s;
  logic              arb_found_s;
  logic              arb_adv_s;
  logic [ADDR_W-1:0] sel_src_s;
  logic [ADDR_W-1:0] sel_dst_s;
  logic [SIZE_W-1:0] sel_size_s;
  logic              sel_src_inc_s;
  logic              sel_dst_inc_s;
  logic [ADDR_W-1:0] src_nxt_s;
  logic [ADDR_W-1:0] dst_nxt_s;
  logic [SIZE_W-1:0] count_dec_s;
  logic              gnt_en_s;

  assign elig_s     = ch_en & req;
  assign any_elig_s = |elig_s;
  assign arb_adv_s  = (state_r == ST_ARB);

  dma_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (elig_s),
    .advance   (arb_adv_s),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .found     (arb_found_s)
  );

  // Select the arbitration winner's configuration for latching in ARB.
  always_comb begin
    sel_src_s     = '0;
    sel_dst_s     = '0;
    sel_size_s    = '0;
    sel_src_inc_s = 1'b0;
    sel_dst_inc_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_idx_s == IDX_W'(i)) begin
        sel_src_s     = ch_src[i*ADDR_W +: ADDR_W];
        sel_dst_s     = ch_dst[i*ADDR_W +: ADDR_W];
        sel_size_s    = ch_size[i*SIZE_W +: SIZE_W];
        sel_src_inc_s = ch_src_inc[i];
        sel_dst_inc_s = ch_dst_inc[i];
      end else begin
        sel_src_s = sel_src_s;
      end
    end
  end

  // Next-beat addresses; plain ADDR_W-bit adds so they wrap naturally.
  always_comb begin
    if (src_inc_r) begin
      src_nxt_s = src_r + STEP;
    end else begin
      src_nxt_s = src_r;
    end
    if (dst_inc_r) begin
      dst_nxt_s = dst_r + STEP;
    end else begin
      dst_nxt_s = dst_r;
    end
  end

  assign count_dec_s = count_r - SIZE_W'(1);
  // Live enable of the running channel; only looked at when a beat retires.
  assign gnt_en_s    = |(ch_en & gnt_r);

  // Transfer FSM; every bus/pulse output is set on the transition into the
  // state that owns it, so the outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      gnt_r     <= '0;
      src_r     <= '0;
      dst_r     <= '0;
      count_r   <= '0;
      src_inc_r <= 1'b0;
      dst_inc_r <= 1'b0;
      buf_r     <= '0;
      htrans_r  <= HTRANS_IDLE;
      hwrite_r  <= 1'b0;
      haddr_r   <= '0;
      hwdata_r  <= '0;
      ack_r     <= '0;
      done_r    <= '0;
      err_r     <= '0;
      busy_r    <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-armed below.
      ack_r  <= '0;
      done_r <= '0;
      err_r  <= '0;
      case (state_r)
        ST_IDLE: begin
          if (any_elig_s) begin
            state_r <= ST_ARB;
            busy_r  <= 1'b1;
          end
        end

        ST_ARB: begin
          if (!arb_found_s) begin
            // Request withdrawn between IDLE and ARB.
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            gnt_r     <= arb_grant_s;
            src_r     <= sel_src_s;
            dst_r     <= sel_dst_s;
            count_r   <= sel_size_s;
            src_inc_r <= sel_src_inc_s;
            dst_inc_r <= sel_dst_inc_s;
            if (sel_size_s == '0) begin
              state_r <= ST_DONE;
              ack_r   <= arb_grant_s;
              done_r  <= arb_grant_s;
            end else begin
              state_r  <= ST_RD_A;
              htrans_r <= HTRANS_NONSEQ;
              hwrite_r <= 1'b0;
              haddr_r  <= sel_src_s;
            end
          end
        end

        ST_RD_A: begin
          if (ahb.hready) begin
            state_r  <= ST_RD_D;
            htrans_r <= HTRANS_IDLE;
          end
        end

        ST_RD_D: begin
          if (ahb.hready) begin
            buf_r <= ahb.hrdata;
            if (ahb.hresp == HRESP_ERR) begin
              state_r <= ST_ERR;
              ack_r   <= gnt_r;
              err_r   <= gnt_r;
            end else begin
              state_r  <= ST_WR_A;
              htrans_r <= HTRANS_NONSEQ;
              hwrite_r <= 1'b1;
              haddr_r  <= dst_r;
            end
          end
        end

        ST_WR_A: begin
          if (ahb.hready) begin
            state_r  <= ST_WR_D;
            htrans_r <= HTRANS_IDLE;
            hwdata_r <= buf_r;
          end
        end

        ST_WR_D: begin
          if (ahb.hready) begin
            if (ahb.hresp == HRESP_ERR) begin
              state_r <= ST_ERR;
              ack_r   <= gnt_r;
              err_r   <= gnt_r;
            end else begin
              count_r <= count_dec_s;
              src_r   <= src_nxt_s;
              dst_r   <= dst_nxt_s;
              if (count_dec_s == '0) begin
                state_r <= ST_DONE;
                ack_r   <= gnt_r;
                done_r  <= gnt_r;
              end else if (!gnt_en_s) begin
                state_r <= ST_ABORT;
                ack_r   <= gnt_r;
              end else begin
                state_r  <= ST_RD_A;
                htrans_r <= HTRANS_NONSEQ;
                hwrite_r <= 1'b0;
                haddr_r  <= src_nxt_s;
              end
            end
          end
        end

        ST_DONE, ST_ABORT, ST_ERR: begin
          // Pulses are visible during this cycle; the IDLE cycle that
          // follows gives the requester time to drop req.
          state_r  <= ST_IDLE;
          hwrite_r <= 1'b0;
          busy_r   <= 1'b0;
        end

        default: begin
          state_r  <= ST_IDLE;
          htrans_r <= HTRANS_IDLE;
          hwrite_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign ahb.htrans = htrans_r;
  assign ahb.hsize  = HSIZE_C;
  assign ahb.hwrite = hwrite_r;
  assign ahb.haddr  = haddr_r;
  assign ahb.hwdata = hwdata_r;
  assign ack        = ack_r;
  assign done       = done_r;
  assign err        = err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Directed bench for dma_xfer_engine with a small zero/extra-wait AHB slave.
// Slave read data for address A is A ^ 32'hA5A5_0000.
module tb_dma_xfer_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   ch_en;
  logic [127:0] ch_src;
  logic [127:0] ch_dst;
  logic [39:0]  ch_size;
  logic [3:0]   ch_src_inc;
  logic [3:0]   ch_dst_inc;
  logic [3:0]   req;
  logic [3:0]   ack;
  logic [3:0]   done;
  logic [3:0]   err;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // slave model state
  logic        wait_en;
  int          err_read_idx;
  logic [31:0] ph_addr;
  logic        ph_valid, ph_write, ph_err;
  logic [31:0] rd_addr_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          ack_cnt[4];
  int          done_cnt[4];

  dma_xfer_engine_if #(.ADDR_W(32), .DATA_W(32)) bus();

  dma_xfer_engine #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .SIZE_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_en      (ch_en),
    .ch_src     (ch_src),
    .ch_dst     (ch_dst),
    .ch_size    (ch_size),
    .ch_src_inc (ch_src_inc),
    .ch_dst_inc (ch_dst_inc),
    .req        (req),
    .ack        (ack),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .ahb        (bus)
  );

  always #5 clk = ~clk;

  // hready: constantly high, or toggling to insert wait states
  always @(posedge clk or posedge rst) begin
    if (rst) bus.hready <= 1'b1;
    else if (wait_en) bus.hready <= ~bus.hready;
    else bus.hready <= 1'b1;
  end

  assign bus.hrdata = ph_addr ^ 32'hA5A5_0000;
  assign bus.hresp  = ph_valid & ph_err;

  // AHB slave: log accepted reads and completed writes
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_valid <= 1'b0;
      ph_write <= 1'b0;
      ph_err   <= 1'b0;
      ph_addr  <= 32'h0;
    end else if (bus.hready) begin
      if (ph_valid && ph_write) begin
        wr_addr_q.push_back(ph_addr);
        wr_data_q.push_back(bus.hwdata);
      end
      ph_valid <= (bus.htrans == 2'b10);
      ph_addr  <= bus.haddr;
      ph_write <= bus.hwrite;
      if (bus.htrans == 2'b10 && !bus.hwrite) begin
        ph_err <= (rd_addr_q.size() == err_read_idx);
        rd_addr_q.push_back(bus.haddr);
      end else begin
        ph_err <= 1'b0;
      end
    end
  end

  // pulse counters
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ack[i]) ack_cnt[i]++;
      if (done[i]) done_cnt[i]++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int c, input logic [31:0] s, input logic [31:0] d,
                     input logic [9:0] n, input logic si, input logic di);
    ch_src[c*32 +: 32]  = s;
    ch_dst[c*32 +: 32]  = d;
    ch_size[c*10 +: 10] = n;
    ch_src_inc[c]       = si;
    ch_dst_inc[c]       = di;
  endtask

  // Wait (bounded) for an ack pulse; reports channel, cycles waited and the
  // cycle at which the first NONSEQ was seen.
  task automatic wait_ack(input int budget, output int ch, output int cycles, output int first_ns);
    ch = -1; cycles = 0; first_ns = -1;
    while (ch < 0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.htrans == 2'b10 && first_ns < 0) first_ns = cycles;
      for (int i = 0; i < 4; i++) if (ack[i]) ch = i;
    end
    total++;
    assert (ch >= 0) else begin
      bad++;
      $error("FAIL ack_timeout: observed=none expected=ack within %0d cycles", budget);
    end
  endtask

  initial begin
    int ch, cyc, fns, brd, bwr, snap, n;
    int exp_order[5];
    exp_order = '{1, 2, 3, 0, 1};
    ch_en = 4'h0; req = 4'h0; ch_src = '0; ch_dst = '0; ch_size = '0;
    ch_src_inc = 4'h0; ch_dst_inc = 4'h0; wait_en = 1'b0; err_read_idx = -1;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_htrans", bus.htrans, 2'b00);
    chk("rst_hwrite", bus.hwrite, 1'b0);
    chk("rst_haddr", bus.haddr, 32'h0);
    chk("rst_hwdata", bus.hwdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pulses", {ack, done, err}, 12'h000);
    chk("rst_hsize", bus.hsize, 3'd2);
    rst = 1'b0; ch_en = 4'hF;
    @(negedge clk);

    // 1: ch0 incrementing copy of 3 words, zero wait
    cfg(0, 32'h100, 32'h200, 10'd3, 1'b1, 1'b1);
    brd = rd_addr_q.size(); bwr = wr_addr_q.size(); snap = done_cnt[0];
    req[0] = 1'b1;
    wait_ack(200, ch, cyc, fns);
    chk("t1_ack_ch", ch, 0);
    chk("t1_done_pulse", done, 4'b0001);
    req[0] = 1'b0;
    chk("t1_beat_cycles", cyc - fns, 12);
    repeat (2) @(negedge clk);
    chk("t1_rd_n", rd_addr_q.size() - brd, 3);
    chk("t1_wr_n", wr_addr_q.size() - bwr, 3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_rd_addr", rd_addr_q[brd+k], 32'h100 + 32'(4*k));
      chk("t1_wr_addr", wr_addr_q[bwr+k], 32'h200 + 32'(4*k));
      chk("t1_wr_data", wr_data_q[bwr+k], 32'hA5A5_0100 + 32'(4*k));
    end
    chk("t1_done_cnt", done_cnt[0] - snap, 1);
    chk("t1_busy", busy, 1'b0);

    // 2: ch1 fixed source, incrementing destination, 4 words
    cfg(1, 32'h300, 32'h400, 10'd4, 1'b0, 1'b1);
    brd = rd_addr_q.size(); bwr = wr_addr_q.size();
    req[1] = 1'b1;
    wait_ack(200, ch, cyc, fns);
    chk("t2_ack_ch", ch, 1);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_rd_n", rd_addr_q.size() - brd, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_rd_addr", rd_addr_q[brd+k], 32'h300);
      chk("t2_wr_addr", wr_addr_q[bwr+k], 32'h400 + 32'(4*k));
    end
    chk("t2_wr_data", wr_data_q[bwr+3], 32'hA5A5_0300);

    // 3: round robin from pointer 0, all four one-word requests
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    for (int i = 0; i < 4; i++) cfg(i, 32'h1000 + 32'(16*i), 32'h2000 + 32'(16*i), 10'd1, 1'b1, 1'b1);
    req = 4'hF;
    for (n = 0; n < 5; n++) begin
      wait_ack(100, ch, cyc, fns);
      chk("t3_grant", ch, exp_order[n]);
      if (ch >= 0) req[ch] = 1'b0;
      if (n == 1) req[1] = 1'b1;
    end
    repeat (2) @(negedge clk);

    // 4: error response on the second read of a 4-word transfer
    cfg(2, 32'h500, 32'h600, 10'd4, 1'b1, 1'b1);
    brd = rd_addr_q.size(); bwr = wr_addr_q.size(); snap = done_cnt[2];
    err_read_idx = brd + 1;
    req[2] = 1'b1;
    wait_ack(200, ch, cyc, fns);
    chk("t4_ack_ch", ch, 2);
    chk("t4_err_pulse", err, 4'b0100);
    chk("t4_done_low", done, 4'b0000);
    req[2] = 1'b0;
    err_read_idx = -1;
    repeat (2) @(negedge clk);
    chk("t4_rd_n", rd_addr_q.size() - brd, 2);
    chk("t4_wr_n", wr_addr_q.size() - bwr, 1);
    chk("t4_wr_addr", wr_addr_q[bwr], 32'h600);
    chk("t4_done_cnt", done_cnt[2] - snap, 0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_htrans", bus.htrans, 2'b00);

    // 5: ch_en dropped during beat 2 of 5 with wait states
    cfg(3, 32'h700, 32'h800, 10'd5, 1'b1, 1'b1);
    brd = rd_addr_q.size(); bwr = wr_addr_q.size(); snap = done_cnt[3];
    wait_en = 1'b1;
    req[3] = 1'b1;
    n = 0;
    while (rd_addr_q.size() - brd < 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t5_beat2_reached", rd_addr_q.size() - brd, 2);
    ch_en[3] = 1'b0;
    wait_ack(300, ch, cyc, fns);
    chk("t5_ack_ch", ch, 3);
    chk("t5_no_done", done, 4'b0000);
    chk("t5_no_err", err, 4'b0000);
    req[3] = 1'b0;
    wait_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_wr_n", wr_addr_q.size() - bwr, 2);
    chk("t5_rd_n", rd_addr_q.size() - brd, 2);
    chk("t5_wr_data", wr_data_q[bwr+1], 32'hA5A5_0704);
    chk("t5_done_cnt", done_cnt[3] - snap, 0);
    ch_en[3] = 1'b1;

    // 6a: reset asserted while in WR_A
    cfg(0, 32'h900, 32'hA00, 10'd2, 1'b1, 1'b1);
    snap = ack_cnt[0];
    req[0] = 1'b1;
    n = 0;
    while (!(bus.htrans == 2'b10 && bus.hwrite) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_wr_a", {bus.htrans, bus.hwrite}, 3'b101);
    rst = 1'b1;
    #1;
    chk("t6_rst_htrans", bus.htrans, 2'b00);
    chk("t6_rst_hwrite", bus.hwrite, 1'b0);
    chk("t6_rst_haddr", bus.haddr, 32'h0);
    chk("t6_rst_hwdata", bus.hwdata, 32'h0);
    chk("t6_rst_busy", busy, 1'b0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_no_ack", ack_cnt[0] - snap, 0);

    // 6b: size 0 completes with no bus traffic
    cfg(1, 32'hB00, 32'hC00, 10'd0, 1'b1, 1'b1);
    brd = rd_addr_q.size(); bwr = wr_addr_q.size();
    req[1] = 1'b1;
    wait_ack(50, ch, cyc, fns);
    chk("t6_zero_ch", ch, 1);
    chk("t6_zero_done", done, 4'b0010);
    chk("t6_zero_latency", cyc, 2);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_zero_rd", rd_addr_q.size() - brd, 0);
    chk("t6_zero_wr", wr_addr_q.size() - bwr, 0);

    // 6c: destination wraps past the top of the address space
    cfg(2, 32'hD00, 32'hFFFF_FFFC, 10'd2, 1'b1, 1'b1);
    bwr = wr_addr_q.size();
    req[2] = 1'b1;
    wait_ack(100, ch, cyc, fns);
    chk("t6_wrap_ch", ch, 2);
    req[2] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_wrap_a0", wr_addr_q[bwr], 32'hFFFF_FFFC);
    chk("t6_wrap_a1", wr_addr_q[bwr+1], 32'h0000_0000);
    chk("t6_wrap_d1", wr_data_q[bwr+1], 32'hA5A5_0D04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
